answer_judge: RTL
=================

Name: answer_judge

Overview:
- Judge and score keeper for the factorization quiz. It is the responder to the game controller.
- Takes the controller's answer handshake (selected choice plus decide strobe) and compares it with the expected answer.
- Drives back the judgement, wrong-count, HP, OK and question-valid signals that the controller consumes.
- Also holds each judgement on the display for a fixed interval and tracks question progress through win or game-over.

Parameters:
- HP_INIT, 3, starting hit points (legal 1..3; fits the 2-bit HP_OUT)
- NUM_Q, 4, number of questions per game (legal 1..8)
- HOLD_CYCLES, 100000000, CLK cycles a judgement is held (1 s at 100 MHz; benches override with a small value)

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous reset, active-high
- READY_IN  input  1  controller ready; starts a game from IDLE
- SEL_IN  input  3  answer choice currently selected by the player
- DEC_IN  input  1  decide request; level input, only the rising edge counts
- CLR_IN  input  1  soft clear; returns the block to the post-reset condition
- ANS_IN  input  3  correct choice for the current question, from the question ROM addressed by QNUM_OUT
- QUE_OUT  output  1  question valid, answer being accepted
- OK_OUT  output  1  one-cycle pulse on a correct answer
- JUDG_OUT  output  2  00 none, 01 correct, 10 wrong, 11 all questions cleared
- WRONG_OUT  output  2  wrong-answer count, saturates at 3
- HP_OUT  output  2  remaining hit points
- QNUM_OUT  output  3  current question index
- NEED_1SEC  output  1  high while a judgement is being held
- STATE_OUT  output  3  FSM state code, for debug and LEDs

Behaviour:
- Reset state, on RST=1 at a clock edge:
  - state IDLE
  - QUE_OUT=0, OK_OUT=0, JUDG_OUT=00, WRONG_OUT=00
  - HP_OUT=HP_INIT, QNUM_OUT=0, NEED_1SEC=0
  - hold counter=0, DEC edge register=0
- CLR_IN=1 has the same effect as RST, from any state. RST has priority when both are asserted. Reset or clear mid-hold abandons the hold immediately.
- DEC edge detection: a registered copy of DEC_IN; dec_rise = DEC_IN & ~dec_q. The register updates every cycle in all states, so a DEC_IN held across a state change does not retrigger.
- All outputs are registered.
- State codes: IDLE=0, ASK=1, JUDGE=2, HOLD=3, OVER=4, WIN=5.
- IDLE:
  - if READY_IN=1 -> ASK, QUE_OUT=1 on the next cycle.
- ASK:
  - QUE_OUT=1.
  - On dec_rise, latch SEL_IN -> JUDGE; QUE_OUT drops to 0 in the same transition.
  - SEL_IN changes without dec_rise are ignored.
- JUDGE (exactly 1 cycle) compares the latched selection with ANS_IN, sampled in this cycle:
  - Equal: JUDG_OUT=01 and OK_OUT=1 for one cycle.
  - Not equal: JUDG_OUT=10; WRONG_OUT+1 saturating at 3; HP_OUT-1 saturating at 0.
  - Then -> HOLD with counter=0 and NEED_1SEC=1.
- HOLD:
  - Counter increments each cycle. JUDG_OUT is held; dec_rise is ignored.
  - When counter == HOLD_CYCLES-1: NEED_1SEC=0 and counter=0, then one of:
    - HP_OUT==0 -> OVER
    - correct and QNUM_OUT==NUM_Q-1 -> WIN
    - correct otherwise -> QNUM_OUT+1, JUDG_OUT=00, ASK
    - wrong with HP>0 -> JUDG_OUT=00, ASK (same question retried)
  - HOLD length is exactly HOLD_CYCLES cycles.
  - Latency from the DEC_IN rising edge to QUE_OUT high again is 2 + HOLD_CYCLES cycles.
- OVER: JUDG_OUT=10, HP_OUT=0, QUE_OUT=0. Left only via RST or CLR_IN.
- WIN: JUDG_OUT=11, QUE_OUT=0, QNUM_OUT frozen at NUM_Q-1. Left only via RST or CLR_IN.
- READY_IN is ignored outside IDLE.
- The hold counter is sized $clog2(HOLD_CYCLES) bits, minimum 1.

Optional Feature:
- Macro HP_REFILL_EN.
- When defined: a correct answer in JUDGE also sets HP_OUT to min(HP_OUT+1, HP_INIT). WRONG_OUT is unaffected.
- When undefined: HP_OUT only decreases, or is restored by RST/CLR_IN.

Test Plan:
1. Setup HOLD_CYCLES=4, NUM_Q=2, ANS_IN=5. RST, then READY_IN=1, SEL_IN=5, DEC_IN rise.
   - OK_OUT pulses once, JUDG_OUT=01.
   - NEED_1SEC high exactly 4 cycles.
   - Then QNUM_OUT=1, JUDG_OUT=00, QUE_OUT=1.
2. Answer both questions correctly.
   - After the second hold: state WIN, JUDG_OUT=11, QUE_OUT=0.
   - A further DEC_IN edge changes nothing.
3. Answer wrong 3 times with HP_INIT=3.
   - HP_OUT steps 2, 1, 0; WRONG_OUT steps 1, 2, 3.
   - After the third hold: state OVER, JUDG_OUT=10.
   - A fourth attempt is impossible; WRONG_OUT stays 3.
4. Hold DEC_IN high continuously through JUDGE and HOLD.
   - Exactly one judgement is made.
   - A new judgement occurs only after DEC_IN goes low then high again in ASK.
5. Assert CLR_IN in mid-HOLD, and separately RST together with DEC_IN.
   - Next cycle: all outputs at reset values, state IDLE, HP_OUT=3.
6. With HP_REFILL_EN defined: answer wrong (HP=2), then correct.
   - HP_OUT=3; a further correct answer keeps HP_OUT=3.
   - Without the macro the same sequence leaves HP_OUT=2.

Source files
------------

// File: rtl/answer_judge_if.sv
// Answer handshake between the quiz controller (master) and the judge (slave).
// Signal names follow the judge's external pin names.
interface answer_judge_if;
    logic       READY_IN;
    logic [2:0] SEL_IN;
    logic       DEC_IN;
    logic       CLR_IN;
    logic [2:0] ANS_IN;
    logic       QUE_OUT;
    logic       OK_OUT;
    logic [1:0] JUDG_OUT;
    logic [1:0] WRONG_OUT;
    logic [1:0] HP_OUT;
    logic [2:0] QNUM_OUT;
    logic       NEED_1SEC;
    logic [2:0] STATE_OUT;

    modport master (
        output READY_IN, SEL_IN, DEC_IN, CLR_IN, ANS_IN,
        input  QUE_OUT, OK_OUT, JUDG_OUT, WRONG_OUT, HP_OUT, QNUM_OUT, NEED_1SEC, STATE_OUT
    );

    modport slave (
        input  READY_IN, SEL_IN, DEC_IN, CLR_IN, ANS_IN,
        output QUE_OUT, OK_OUT, JUDG_OUT, WRONG_OUT, HP_OUT, QNUM_OUT, NEED_1SEC, STATE_OUT
    );
endinterface

// File: rtl/answer_judge.sv
// Judge and score keeper for the factorization quiz; all outputs registered.
// Define HP_REFILL_EN to restore one HP (capped at HP_INIT) on each correct answer.
module answer_judge #(
    parameter int unsigned HP_INIT     = 3,
    parameter int unsigned NUM_Q       = 4,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input logic            CLK,
    input logic            RST,
    answer_judge_if.slave  bus
);
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [1:0] HpInit = 2'(HP_INIT);
    localparam logic [2:0] QLast  = 3'(NUM_Q - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAsk   = 3'd1,
        StJudge = 3'd2,
        StHold  = 3'd3,
        StOver  = 3'd4,
        StWin   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            que_q, que_d;
    logic            ok_q, ok_d;
    logic [1:0]      judg_q, judg_d;
    logic [1:0]      wrong_q, wrong_d;
    logic [1:0]      hp_q, hp_d;
    logic [2:0]      qnum_q, qnum_d;
    logic            need_q, need_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dec_q, dec_d;
    logic [2:0]      sel_q, sel_d;
    logic            dec_rise;

    assign dec_rise = bus.DEC_IN & ~dec_q;

    always_comb begin
        state_d = state_q;
        que_d   = que_q;
        ok_d    = 1'b0;
        judg_d  = judg_q;
        wrong_d = wrong_q;
        hp_d    = hp_q;
        qnum_d  = qnum_q;
        need_d  = need_q;
        cnt_d   = cnt_q;
        dec_d   = bus.DEC_IN;
        sel_d   = sel_q;

        if (bus.CLR_IN) begin
            state_d = StIdle;
            que_d   = 1'b0;
            judg_d  = 2'b00;
            wrong_d = 2'b00;
            hp_d    = HpInit;
            qnum_d  = 3'd0;
            need_d  = 1'b0;
            cnt_d   = '0;
            dec_d   = 1'b0;
            sel_d   = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.READY_IN) begin
                        state_d = StAsk;
                        que_d   = 1'b1;
                    end
                end
                StAsk: begin
                    que_d = 1'b1;
                    if (dec_rise) begin
                        sel_d   = bus.SEL_IN;
                        state_d = StJudge;
                        que_d   = 1'b0;
                    end
                end
                StJudge: begin
                    state_d = StHold;
                    need_d  = 1'b1;
                    cnt_d   = '0;
                    if (sel_q == bus.ANS_IN) begin
                        judg_d = 2'b01;
                        ok_d   = 1'b1;
`ifdef HP_REFILL_EN
                        hp_d   = (hp_q < HpInit) ? hp_q + 2'd1 : HpInit;
`else
                        hp_d   = hp_q;
`endif
                    end else begin
                        judg_d  = 2'b10;
                        wrong_d = (wrong_q == 2'd3) ? 2'd3 : wrong_q + 2'd1;
                        hp_d    = (hp_q == 2'd0) ? 2'd0 : hp_q - 2'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == CntLast) begin
                        cnt_d  = '0;
                        need_d = 1'b0;
                        if (hp_q == 2'd0) begin
                            state_d = StOver;
                            judg_d  = 2'b10;
                        end else if (judg_q == 2'b01 && qnum_q == QLast) begin
                            state_d = StWin;
                            judg_d  = 2'b11;
                        end else begin
                            // Correct advances the question; wrong retries the same one.
                            if (judg_q == 2'b01) qnum_d = qnum_q + 3'd1;
                            judg_d  = 2'b00;
                            state_d = StAsk;
                            que_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StOver: begin
                    judg_d = 2'b10;
                    hp_d   = 2'd0;
                    que_d  = 1'b0;
                end
                StWin: begin
                    judg_d = 2'b11;
                    que_d  = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            que_q   <= 1'b0;
            ok_q    <= 1'b0;
            judg_q  <= 2'b00;
            wrong_q <= 2'b00;
            hp_q    <= HpInit;
            qnum_q  <= 3'd0;
            need_q  <= 1'b0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            que_q   <= que_d;
            ok_q    <= ok_d;
            judg_q  <= judg_d;
            wrong_q <= wrong_d;
            hp_q    <= hp_d;
            qnum_q  <= qnum_d;
            need_q  <= need_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.QUE_OUT   = que_q;
    assign bus.OK_OUT    = ok_q;
    assign bus.JUDG_OUT  = judg_q;
    assign bus.WRONG_OUT = wrong_q;
    assign bus.HP_OUT    = hp_q;
    assign bus.QNUM_OUT  = qnum_q;
    assign bus.NEED_1SEC = need_q;
    assign bus.STATE_OUT = state_q;
endmodule
